updown_counter_ctl: RTL
=======================

// Module: updown_counter_ctl
// PURPOSE
//  Parametrised up/down counter with run/pause, four speed settings, and synchronous load.
//  Counts 0..MOD_MAX; at the bound it either wraps or saturates.
//  Emits a step strobe and a terminal-count pulse.
//  Drives display/state-machine logic that needs a controllable, rate-selectable count.
// PARAMETERS
//  N        8    counter width
//  MOD_MAX  255  upper count bound, 0 <= MOD_MAX <= 2^N-1
//  SHIFT    4    speed step; divisor for spd=k is 2^(k*SHIFT)
// PORTS
//  clk    in   1    single clock, rising edge
//  reset  in   1    asynchronous, active-low (0 = reset)
//  en     in   1    1 = run, 0 = pause
//  ud     in   1    0 = count up, 1 = count down
//  spd    in   2    speed select; 0 = every clock, 3 = slowest
//  sat    in   1    0 = wrap at bound, 1 = saturate at bound
//  load   in   1    synchronous load of din
//  din    in   N    load value
//  q      out  N    count value (registered)
//  tick   out  1    1-cycle pulse, high in the cycle q shows a stepped value
//  tc     out  1    1-cycle pulse, high when that step was taken at a bound
// BEHAVIOUR
//  - Reset (reset=0, async): q=0, tick=0, tc=0, prescaler=0.
//  - Priority per edge: load > pause > step.
//  - load=1: q <= min(din, MOD_MAX); prescaler <= 0; tick=0; tc=0.
//    Overrides en and any pending step.
//  - en=0 (no load): q and prescaler hold; tick=0, tc=0.
//    Resuming continues the interrupted interval; it does not restart it.
//  - Prescaler (PW = 3*SHIFT bits), en=1:
//    - step = (pre >= DIV(spd)-1), where DIV(k) = 2^(k*SHIFT).
//    - On step, pre <= 0; otherwise pre <= pre+1.
//    - Use >= so a spd decrease mid-interval steps on the next edge; no lockup.
//    - spd=0: step on every enabled clock.
//  - Step, up (ud=0):
//    - q<MOD_MAX: q+1.
//    - q==MOD_MAX: q <= 0 if sat=0, else hold; tc=1 in both cases.
//  - Step, down (ud=1):
//    - q>0: q-1.
//    - q==0: q <= MOD_MAX if sat=0, else hold; tc=1 in both cases.
//  - tick and tc are registered at the same edge as q, so they align with the new q.
//    No combinational path from inputs to outputs.
//  - Latency: with spd=0, the first change of q is at the first rising edge that samples en=1.
//  - ud, sat and spd are sampled only at a step edge; changing them never causes a glitch or double step.
//  - MOD_MAX=0: q stays 0; tc=tick=1 on every step.
//  - Arithmetic is N-bit unsigned; compare against MOD_MAX, never rely on natural 2^N overflow.
//  - Reset asserted mid-interval clears everything immediately.
//    The first step after release follows a full DIV(spd) interval.
// STRUCTURE
//  - Package counter_pkg:
//    - DIR_UP=1'b0, DIR_DOWN=1'b1
//    - SPD_X1=2'd0 .. SPD_X3=2'd3
//    - MODE_WRAP=1'b0, MODE_SAT=1'b1
//  - Sub-module counter_prescaler:
//    - params SHIFT; ports clk, reset, en, clr, spd -> step.
//    - clr is driven by load.
//  - Top: count/bound logic plus output registers.
// TESTING  (N=4, MOD_MAX=9, SHIFT=2 unless noted)
//  1 reset=0 then release; en=1, spd=0, ud=0, sat=0, 12 clocks
//    -> q 1..9,0,1,2; tc=1 only on the edge q shows 0.
//  2 spd=1 (DIV=4), en=1 from q=0 -> q steps every 4th edge.
//    Drop en for 2 clocks at pre=2 -> step is delayed by exactly 2 clocks.
//  3 ud=1, sat=1, load din=2, run spd=0 -> q 1,0,0,0.
//    tc=1 on each step at q==0; tick=1 every clock.
//  4 load din=13 (>MOD_MAX) together with en=1 -> q=9 next edge, tick=0.
//    Then up, sat=0 -> q=0 with tc=1.
//  5 spd=3 (DIV=64), wait 40 clocks, switch spd=1 -> step on next edge (pre>=3).
//    Then every 4 clocks.
//  6 assert reset async mid-count at q=5 -> q=0, tick=tc=0 before the next edge.
//    Held through 3 clocks -> no change.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared encodings for the up/down counter: direction, speed select and bound mode.
package counter_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam logic [1:0] SPD_X1      = 2'd0;
  localparam logic [1:0] SPD_X2      = 2'd1;
  localparam logic [1:0] SPD_X2_SLOW = 2'd2;
  localparam logic [1:0] SPD_X3      = 2'd3;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/counter_prescaler.sv
// Rate divider: asserts step once every 2^(spd*SHIFT) enabled clocks.
// Pausing holds the interval position; clr restarts it.
module counter_prescaler #(
  parameter int unsigned SHIFT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] spd,
  output logic       step
);

  localparam int unsigned PW = 3 * SHIFT;

  logic [PW-1:0] pre;
  logic [PW:0]   div;
  logic [PW-1:0] lim;

  // One extra bit keeps 2^(3*SHIFT) representable before subtracting one.
  always_comb begin
    div  = (PW+1)'(1) << (32'(spd) * SHIFT);
    lim  = PW'(div - (PW+1)'(1));
    step = en && !clr && (pre >= lim);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre <= '0;
    end else if (clr) begin
      pre <= '0;
    end else if (en) begin
      pre <= step ? '0 : pre + PW'(1);
    end
  end

endmodule

// File: rtl/updown_counter_ctl.sv
// Up/down counter with run/pause, selectable rate, wrap/saturate bound and sync load.
// q, tick and tc are all registered on the same edge.
module updown_counter_ctl
  import counter_pkg::*;
#(
  parameter int unsigned N       = 8,
  parameter int unsigned MOD_MAX = 255,
  parameter int unsigned SHIFT   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         ud,
  input  logic [1:0]   spd,
  input  logic         sat,
  input  logic         load,
  input  logic [N-1:0] din,
  output logic [N-1:0] q,
  output logic         tick,
  output logic         tc
);

  localparam logic [N-1:0] MAX_Q = N'(MOD_MAX);

  logic         step;
  logic [N-1:0] q_nxt;
  logic         tick_nxt;
  logic         tc_nxt;

  counter_prescaler #(
    .SHIFT (SHIFT)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clr   (load),
    .spd   (spd),
    .step  (step)
  );

  // Next count: load beats step; bounds compared explicitly, no reliance on overflow.
  always_comb begin
    q_nxt    = q;
    tick_nxt = 1'b0;
    tc_nxt   = 1'b0;
    if (load) begin
      q_nxt = (din > MAX_Q) ? MAX_Q : din;
    end else if (step) begin
      tick_nxt = 1'b1;
      if (ud == DIR_UP) begin
        if (q >= MAX_Q) begin
          tc_nxt = 1'b1;
          q_nxt  = (sat == MODE_SAT) ? q : '0;
        end else begin
          q_nxt = q + N'(1);
        end
      end else begin
        if (q == '0) begin
          tc_nxt = 1'b1;
          q_nxt  = (sat == MODE_SAT) ? q : MAX_Q;
        end else begin
          q_nxt = q - N'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q    <= '0;
      tick <= 1'b0;
      tc   <= 1'b0;
    end else begin
      q    <= q_nxt;
      tick <= tick_nxt;
      tc   <= tc_nxt;
    end
  end

endmodule
